div_request_scheduler: RTL and testbench

Request front-end for the 16-bit restoring divider. It buffers signed numerator/denominator pairs in a small FIFO and issues them one at a time over the divider's start/done interface. It captures each quotient into a valid/ready output register. The block sits directly upstream of the divider and owns its `start` line; the divider's `quotient`/`done` return to this block.

---
 rtl/div_request_scheduler_if.sv | 30 +++
 rtl/div_request_scheduler.sv | 133 +++++++++++++
 tb/tb_div_request_scheduler.sv | 343 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/div_request_scheduler_if.sv
// Bundle between the request source, the divider and the result consumer.
// slave is the scheduler's view; master is the surrounding environment.
interface div_request_scheduler_if #(parameter int WIDTH = 16);
  // Valid/ready: a transfer happens on a rising clk edge where valid && ready.
  // Once valid rises, it and its data stay stable until that edge.
  // div_start and div_done are single-cycle pulses with no back-pressure.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_numerator;
  logic [WIDTH-1:0] in_denominator;
  logic             div_start;
  logic [WIDTH-1:0] div_numerator;
  logic [WIDTH-1:0] div_denominator;
  logic [WIDTH-1:0] div_quotient;
  logic             div_done;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_quotient;
  logic             out_dbz;

  modport slave (
    input  in_valid, in_numerator, in_denominator, div_quotient, div_done, out_ready,
    output in_ready, div_start, div_numerator, div_denominator, out_valid, out_quotient, out_dbz
  );

  modport master (
    output in_valid, in_numerator, in_denominator, div_quotient, div_done, out_ready,
    input  in_ready, div_start, div_numerator, div_denominator, out_valid, out_quotient, out_dbz
  );
endinterface

// File: rtl/div_request_scheduler.sv
// Request FIFO and single-outstanding issue FSM in front of the restoring divider.
// Optional macro DIV_ZERO_BYPASS_EN answers zero-denominator requests locally.
module div_request_scheduler #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  div_request_scheduler_if.slave       bus,
  output logic [1:0]                   fsm_state
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] HOLD  = 2'd3;

  logic [1:0]       state, state_nxt;
  logic [WIDTH-1:0] num_mem [DEPTH];
  logic [WIDTH-1:0] den_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop, issue_entry, head_zero, bypass;
  logic             start_q, valid_q;
  logic [WIDTH-1:0] num_q, den_q, quot_q;

  assign bus.in_ready        = (count != FULL);
  assign push                = bus.in_valid && bus.in_ready;
  assign pop                 = (state == ISSUE);
  assign bus.div_start       = start_q;
  assign bus.div_numerator   = num_q;
  assign bus.div_denominator = den_q;
  assign bus.out_valid       = valid_q;
  assign bus.out_quotient    = quot_q;
  assign fsm_state           = state;

`ifdef DIV_ZERO_BYPASS_EN
  logic dbz_q;
  assign head_zero   = (den_mem[rd_ptr] == '0);
  // den_q holds the popped head while in ISSUE
  assign bypass      = (state == ISSUE) && (den_q == '0);
  assign bus.out_dbz = dbz_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dbz_q <= 1'b0;
    end else if (bypass) begin
      dbz_q <= 1'b1;
    end else if (state == WAIT && bus.div_done) begin
      dbz_q <= 1'b0;
    end
  end
`else
  assign head_zero   = 1'b0;
  assign bypass      = 1'b0;
  assign bus.out_dbz = 1'b0;
`endif

  always_comb begin
    state_nxt   = state;
    issue_entry = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_nxt   = ISSUE;
          issue_entry = 1'b1;
        end
      end
      ISSUE: state_nxt = bypass ? HOLD : WAIT;
      WAIT: begin
        if (bus.div_done) state_nxt = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          if (count != '0) begin
            state_nxt   = ISSUE;
            issue_entry = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Storage needs no reset: entries are only read when count says they are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      num_mem[wr_ptr] <= bus.in_numerator;
      den_mem[wr_ptr] <= bus.in_denominator;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      start_q <= 1'b0;
      num_q   <= '0;
      den_q   <= '0;
      valid_q <= 1'b0;
      quot_q  <= '0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
      start_q <= issue_entry && !head_zero;
      if (issue_entry) begin
        num_q <= num_mem[rd_ptr];
        den_q <= den_mem[rd_ptr];
      end
      if (state == WAIT && bus.div_done) begin
        quot_q  <= bus.div_quotient;
        valid_q <= 1'b1;
      end
      if (bypass) begin
        quot_q  <= '1;
        valid_q <= 1'b1;
      end
      if (state == HOLD && bus.out_ready) valid_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_div_request_scheduler.sv
// Directed bench for div_request_scheduler with a behavioural 16-bit divider
// (start sampled at edge S, done sampled at edge S+18).
module tb_div_request_scheduler;
  localparam int WIDTH = 16;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd2;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] fsm_state;
  logic       stray_done = 1'b0;

  div_request_scheduler_if #(.WIDTH(WIDTH)) bus();

  div_request_scheduler #(.DEPTH(4), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus.slave),
    .fsm_state (fsm_state)
  );

  // ---------------- clock / reset / cycle count ----------------
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // ---------------- divider model ----------------
  logic [4:0]  div_cnt;
  logic [15:0] div_q;

  function automatic logic [15:0] ref_div(input logic [15:0] n, input logic [15:0] d);
    if (d == 16'd0) return 16'hFFFF;
    return 16'($signed(n) / $signed(d));
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_cnt <= '0;
      div_q   <= '0;
    end else if (bus.div_start) begin
      div_cnt <= 5'd18;
      div_q   <= ref_div(bus.div_numerator, bus.div_denominator);
    end else if (div_cnt != 0) begin
      div_cnt <= div_cnt - 5'd1;
    end
  end
  assign bus.div_done     = (div_cnt == 5'd1) | stray_done;
  assign bus.div_quotient = div_q;

  // ---------------- monitor / scoreboard ----------------
  int          start_count = 0;
  int          overlap = 0;
  logic [15:0] res_q[$];
  int          res_t[$];
  logic [15:0] exp_q[$];

  always @(posedge clk) begin
    if (reset) begin
      if (bus.div_start) begin
        start_count++;
        if (bus.out_valid) overlap++;
      end
      if (bus.out_valid && bus.out_ready) begin
        res_q.push_back(bus.out_quotient);
        res_t.push_back(cyc);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks ----------------
  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic push_req(input logic [15:0] n, input logic [15:0] d);
    int guard;
    bus.in_valid       = 1'b1;
    bus.in_numerator   = n;
    bus.in_denominator = d;
    guard = 0;
    while (!bus.in_ready && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL push_timeout in_ready=%b waited=%0d cycles", bus.in_ready, guard);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_results(input int n, input int bound, input string name);
    int guard;
    guard = 0;
    while (res_q.size() < n && guard < bound) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (res_q.size() < n) begin
      errors++;
      $display("FAIL %s_timeout got=%0d results required=%0d", name, res_q.size(), n);
    end
  endtask

  task automatic check_results(input string name);
    logic [15:0] e, g;
    int idx;
    idx = 0;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      g = (res_q.size() != 0) ? res_q.pop_front() : 16'hxxxx;
      checks++;
      if (g !== e) begin
        errors++;
        $display("FAIL %s_result[%0d] got=%h required=%h", name, idx, g, e);
      end
      idx++;
    end
    checks++;
    if (res_q.size() != 0) begin
      errors++;
      $display("FAIL %s_extra_results got=%0d required=0", name, res_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 8;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b required=1", bus.in_ready); end
    if (bus.div_start !== 1'b0) begin errors++; $display("FAIL reset_div_start got=%b required=0", bus.div_start); end
    if (bus.div_numerator !== 16'h0) begin errors++; $display("FAIL reset_div_num got=%h required=0000", bus.div_numerator); end
    if (bus.div_denominator !== 16'h0) begin errors++; $display("FAIL reset_div_den got=%h required=0000", bus.div_denominator); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b required=0", bus.out_valid); end
    if (bus.out_quotient !== 16'h0) begin errors++; $display("FAIL reset_out_quotient got=%h required=0000", bus.out_quotient); end
    if (bus.out_dbz !== 1'b0) begin errors++; $display("FAIL reset_out_dbz got=%b required=0", bus.out_dbz); end
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL reset_state got=%0d required=0", fsm_state); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_single();
    int s0, t0, got_start, got_valid, vcnt;
    logic [15:0] sn, sd, gq;
    logic gdbz;
    bus.out_ready = 1'b1;
    res_q.delete(); res_t.delete();
    s0 = start_count;
    push_req(16'd100, 16'd7);
    t0 = cyc; got_start = -1; got_valid = -1; vcnt = 0;
    sn = 'x; sd = 'x; gq = 'x; gdbz = 1'bx;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.div_start && got_start < 0) begin
        got_start = cyc; sn = bus.div_numerator; sd = bus.div_denominator;
      end
      if (bus.out_valid) begin
        vcnt++;
        if (got_valid < 0) begin got_valid = cyc; gq = bus.out_quotient; gdbz = bus.out_dbz; end
      end
    end
    checks += 8;
    if (got_start != t0 + 1) begin errors++; $display("FAIL single_start_cycle got=%0d required=%0d", got_start - t0, 1); end
    if (sn !== 16'd100 || sd !== 16'd7) begin errors++; $display("FAIL single_operands got=%0d/%0d required=100/7", sn, sd); end
    if (start_count - s0 != 1) begin errors++; $display("FAIL single_start_pulses got=%0d required=1", start_count - s0); end
    if (got_valid != t0 + 20) begin errors++; $display("FAIL single_valid_cycle got=T+%0d required=T+20", got_valid - t0); end
    if (gq !== 16'd14) begin errors++; $display("FAIL single_quotient got=%h required=000e", gq); end
    if (gdbz !== 1'b0) begin errors++; $display("FAIL single_dbz got=%b required=0", gdbz); end
    if (vcnt != 1) begin errors++; $display("FAIL single_valid_width got=%0d required=1", vcnt); end
    if (res_q.size() != 1) begin errors++; $display("FAIL single_handshakes got=%0d required=1", res_q.size()); end
  endtask

  task automatic test_back_to_back();
    int s0, o0;
    bus.out_ready = 1'b1;
    res_q.delete(); res_t.delete();
    s0 = start_count; o0 = overlap;
    exp_q.push_back(16'hFFF2); exp_q.push_back(16'hFFF2); exp_q.push_back(16'h000E);
    push_req(-16'sd100, 16'd7);
    push_req(16'd100, -16'sd7);
    push_req(-16'sd100, -16'sd7);
    wait_results(3, 200, "b2b");
    checks += 3;
    if (res_t.size() < 3 || res_t[1] - res_t[0] != 20 || res_t[2] - res_t[1] != 20) begin
      errors++;
      $display("FAIL b2b_throughput got=%0d results, spacing must be 20 cycles", res_t.size());
    end
    if (start_count - s0 != 3) begin errors++; $display("FAIL b2b_start_pulses got=%0d required=3", start_count - s0); end
    if (overlap != o0) begin errors++; $display("FAIL b2b_start_during_valid got=%0d required=0", overlap - o0); end
    check_results("b2b");
  endtask

  task automatic test_backpressure();
    int s0;
    bus.out_ready = 1'b0;
    res_q.delete(); res_t.delete();
    s0 = start_count;
    exp_q.push_back(16'h0064); exp_q.push_back(16'hFFF6); exp_q.push_back(16'h000B);
    exp_q.push_back(16'h8001); exp_q.push_back(16'hC000);
    push_req(16'd1000, 16'd10);
    push_req(-16'sd50, 16'd5);
    push_req(16'd77, 16'd7);
    push_req(16'd32767, -16'sd1);
    push_req(16'h8000, 16'd2);
    checks++;
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_full_in_ready got=%b required=0", bus.in_ready); end
    repeat (40) @(negedge clk);
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid got=%b required=1", bus.out_valid); end
    if (bus.out_quotient !== 16'h0064) begin errors++; $display("FAIL bp_hold_quotient got=%h required=0064", bus.out_quotient); end
    if (start_count - s0 != 1) begin errors++; $display("FAIL bp_single_outstanding got=%0d required=1", start_count - s0); end
    if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_still_full got=%b required=0", bus.in_ready); end
    bus.out_ready = 1'b1;
    wait_results(5, 300, "bp");
    checks += 2;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_drained_in_ready got=%b required=1", bus.in_ready); end
    if (start_count - s0 != 5) begin errors++; $display("FAIL bp_start_pulses got=%0d required=5", start_count - s0); end
    check_results("bp");
  endtask

  task automatic test_reset_mid();
    int guard, s0, vseen;
    bus.out_ready = 1'b1;
    push_req(16'd20, 16'd4);
    push_req(16'd30, 16'd5);
    push_req(16'd40, 16'd8);
    guard = 0;
    while (fsm_state != S_WAIT && guard < 20) begin @(negedge clk); guard++; end
    checks++;
    if (fsm_state !== S_WAIT) begin errors++; $display("FAIL rst_reach_wait got=%0d required=2", fsm_state); end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    #1;
    checks += 6;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready got=%b required=1", bus.in_ready); end
    if (bus.div_numerator !== 16'h0) begin errors++; $display("FAIL rst_mid_div_num got=%h required=0000", bus.div_numerator); end
    if (bus.div_denominator !== 16'h0) begin errors++; $display("FAIL rst_mid_div_den got=%h required=0000", bus.div_denominator); end
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid got=%b required=0", bus.out_valid); end
    if (bus.div_start !== 1'b0) begin errors++; $display("FAIL rst_mid_div_start got=%b required=0", bus.div_start); end
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL rst_mid_state got=%0d required=0", fsm_state); end
    @(negedge clk);
    reset = 1'b1;
    res_q.delete(); res_t.delete();
    s0 = start_count;
    @(negedge clk);
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    vseen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid) vseen++;
    end
    checks += 2;
    if (vseen != 0 || res_q.size() != 0) begin errors++; $display("FAIL rst_late_done_valid got=%0d required=0", vseen); end
    if (start_count != s0) begin errors++; $display("FAIL rst_queue_discarded got=%0d starts required=0", start_count - s0); end
    exp_q.push_back(16'd3);
    push_req(16'd9, 16'd3);
    wait_results(1, 60, "rst_new");
    check_results("rst_new");
  endtask

  task automatic test_stray_done();
    int vseen;
    repeat (2) @(negedge clk);
    checks++;
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL stray_pre_state got=%0d required=0", fsm_state); end
    stray_done = 1'b1;
    @(negedge clk);
    stray_done = 1'b0;
    vseen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (bus.out_valid) vseen++;
    end
    checks += 2;
    if (vseen != 0) begin errors++; $display("FAIL stray_out_valid got=%0d cycles required=0", vseen); end
    if (fsm_state !== S_IDLE) begin errors++; $display("FAIL stray_state got=%0d required=0", fsm_state); end
  endtask

  task automatic test_div_zero();
    int s0, t0;
`ifdef DIV_ZERO_BYPASS_EN
    bus.out_ready = 1'b0;
    s0 = start_count;
    push_req(16'd5, 16'd0);
    t0 = cyc;
    while (cyc < t0 + 3) @(negedge clk);
    checks += 4;
    if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dbz_valid got=%b required=1", bus.out_valid); end
    if (bus.out_quotient !== 16'hFFFF) begin errors++; $display("FAIL dbz_quotient got=%h required=ffff", bus.out_quotient); end
    if (bus.out_dbz !== 1'b1) begin errors++; $display("FAIL dbz_flag got=%b required=1", bus.out_dbz); end
    if (start_count != s0) begin errors++; $display("FAIL dbz_no_start got=%0d required=0", start_count - s0); end
    bus.out_ready = 1'b1;
    repeat (3) @(negedge clk);
`else
    logic [15:0] sd, gq;
    logic gdbz;
    int got_valid;
    bus.out_ready = 1'b1;
    s0 = start_count;
    push_req(16'd5, 16'd0);
    t0 = cyc; got_valid = -1; sd = 'x; gq = 'x; gdbz = 1'bx;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.div_start) sd = bus.div_denominator;
      if (bus.out_valid && got_valid < 0) begin got_valid = cyc; gq = bus.out_quotient; gdbz = bus.out_dbz; end
    end
    checks += 5;
    if (start_count - s0 != 1) begin errors++; $display("FAIL dz_start_pulses got=%0d required=1", start_count - s0); end
    if (sd !== 16'h0) begin errors++; $display("FAIL dz_operand got=%h required=0000", sd); end
    if (got_valid != t0 + 20) begin errors++; $display("FAIL dz_valid_cycle got=T+%0d required=T+20", got_valid - t0); end
    if (gq !== 16'hFFFF) begin errors++; $display("FAIL dz_quotient got=%h required=ffff", gq); end
    if (gdbz !== 1'b0) begin errors++; $display("FAIL dz_flag got=%b required=0", gdbz); end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    bus.in_valid       = 1'b0;
    bus.in_numerator   = '0;
    bus.in_denominator = '0;
    bus.out_ready      = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_reset_mid();
    test_stray_done();
    test_div_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
